// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 6-stage pipeline: merges stall requests into pause[5:0],
// sequences exception redirects (RUN->FREEZE->FLUSH), runs a stall watchdog. Optional macro: PIPE_CTRL_PERF_EN.
module pipeline_ctrl #(
  parameter int unsigned STALL_TIMEOUT = 1024,
  parameter logic [31:0] EXC_VECTOR    = 32'h1C000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_stall_req,
  input  logic        id_stall_req,
  input  logic        ex_stall_req,
  input  logic        mem_stall_req,
  input  logic        exc_req,
  output logic [5:0]  pause,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FREEZE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  localparam logic [15:0] LP_TIMEOUT = 16'(STALL_TIMEOUT);

  state_t      r_state;
  logic        r_flush;
  logic [31:0] r_new_pc;
  logic [15:0] r_wd;
  logic        r_timeout;

  logic [5:0]  w_pause;
  logic [15:0] w_wd_next;

  // pause follows the requests in the same cycle; the exception wins over every stall.
  always_comb begin
    w_pause = 6'b000000;
    case (r_state)
      ST_RUN: begin
        if (exc_req)            w_pause = 6'b111111;
        else if (mem_stall_req) w_pause = 6'b011111;
        else if (ex_stall_req)  w_pause = 6'b001111;
        else if (id_stall_req)  w_pause = 6'b000111;
        else if (if_stall_req)  w_pause = 6'b000011;
        else                    w_pause = 6'b000000;
      end
      ST_FREEZE: w_pause = 6'b111111;
      ST_FLUSH:  w_pause = 6'b000000;
      default:   w_pause = 6'b000000;
    endcase
  end

  // Watchdog counts only uninterrupted stalls seen in RUN, saturating at all-ones.
  always_comb begin
    w_wd_next = 16'd0;
    if (r_state == ST_RUN && w_pause != 6'b000000) begin
      w_wd_next = (r_wd == 16'hFFFF) ? r_wd : r_wd + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_flush   <= 1'b0;
      r_new_pc  <= 32'h0;
      r_wd      <= 16'd0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_flush <= 1'b0;
          if (exc_req) r_state <= ST_FREEZE;
        end
        ST_FREEZE: begin
          r_state  <= ST_FLUSH;
          r_flush  <= 1'b1;
          r_new_pc <= EXC_VECTOR;
        end
        ST_FLUSH: begin
          r_state <= ST_RUN;
          r_flush <= 1'b0;
        end
        default: begin
          r_state <= ST_RUN;
          r_flush <= 1'b0;
        end
      endcase
      r_wd <= w_wd_next;
      if (w_wd_next >= LP_TIMEOUT) r_timeout <= 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  // Both counters wrap naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= 32'h0;
      r_flush_count  <= 32'h0;
    end else begin
      if (w_pause != 6'b000000) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (r_flush)              r_flush_count  <= r_flush_count + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`else
  assign stall_cycles = 32'h0;
  assign flush_count  = 32'h0;
`endif

  assign pause         = w_pause;
  assign flush         = r_flush;
  assign new_pc        = r_new_pc;
  assign stall_timeout = r_timeout;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: stage-level reference model, directed scenarios and random traffic.
module tb_pipeline_ctrl;
  localparam int          TO  = 8;
  localparam logic [31:0] VEC = 32'h1C000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_stall_req, id_stall_req, ex_stall_req, mem_stall_req, exc_req;
  logic [5:0]  pause;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] stall_cycles, flush_count;
  logic [1:0]  o_dbg_state;

  pipeline_ctrl #(.STALL_TIMEOUT(TO), .EXC_VECTOR(VEC)) dut (
    .clk(clk), .rst(rst),
    .if_stall_req(if_stall_req), .id_stall_req(id_stall_req),
    .ex_stall_req(ex_stall_req), .mem_stall_req(mem_stall_req),
    .exc_req(exc_req), .pause(pause), .flush(flush), .new_pc(new_pc),
    .stall_timeout(stall_timeout), .stall_cycles(stall_cycles),
    .flush_count(flush_count), .o_dbg_state(o_dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: m_busy = cycles left in the exception sequence (2 = freeze, 1 = flush).
  int          m_busy, m_run_len;
  logic        m_timeout;
  logic [31:0] m_new_pc, m_stall_cnt, m_flush_cnt;
  logic [5:0]  cur_pause;
  logic [5:0]  exp_q[$];
  logic        exp_flush, exp_timeout;
  logic [31:0] exp_new_pc, exp_sc, exp_fc;
  logic [1:0]  exp_state;
  logic [5:0]  got_exp;

  task automatic model_reset();
    m_busy = 0; m_run_len = 0; m_timeout = 1'b0;
    m_new_pc = 32'h0; m_stall_cnt = 32'h0; m_flush_cnt = 32'h0;
    exp_q.delete();
  endtask

  // req = {exc, mem, ex, id, if}
  task automatic apply(input logic [4:0] req);
    int hi;
    {exc_req, mem_stall_req, ex_stall_req, id_stall_req, if_stall_req} = req;
    hi = 0;
    for (int k = 1; k <= 4; k++) if (req[k-1]) hi = k;
    if (m_busy == 2)      cur_pause = 6'h3F;
    else if (m_busy == 1) cur_pause = 6'h00;
    else if (req[4])      cur_pause = 6'h3F;
    else if (hi > 0)      cur_pause = 6'((1 << (hi + 1)) - 1);
    else                  cur_pause = 6'h00;
    exp_q.push_back(cur_pause);
    exp_flush   = (m_busy == 1);
    exp_new_pc  = m_new_pc;
    exp_timeout = m_timeout;
    exp_state   = (m_busy == 0) ? 2'd0 : (m_busy == 2) ? 2'd1 : 2'd2;
`ifdef PIPE_CTRL_PERF_EN
    exp_sc = m_stall_cnt; exp_fc = m_flush_cnt;
`else
    exp_sc = 32'h0; exp_fc = 32'h0;
`endif
  endtask

  task automatic advance(input logic [4:0] req);
    if (m_busy == 0 && cur_pause != 6'h00)
      m_run_len = (m_run_len < 65535) ? m_run_len + 1 : m_run_len;
    else
      m_run_len = 0;
    if (m_run_len >= TO) m_timeout = 1'b1;
    if (cur_pause != 6'h00) m_stall_cnt = m_stall_cnt + 32'd1;
    if (m_busy == 1) m_flush_cnt = m_flush_cnt + 32'd1;
    if (m_busy == 0 && req[4]) m_busy = 2;
    else if (m_busy > 0) m_busy = m_busy - 1;
    if (m_busy == 1) m_new_pc = VEC;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {exc_req, mem_stall_req, ex_stall_req, id_stall_req, if_stall_req} = 5'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if (pause !== 6'h00 || flush !== 1'b0 || new_pc !== 32'h0 || stall_timeout !== 1'b0 ||
        stall_cycles !== 32'h0 || flush_count !== 32'h0 || o_dbg_state !== 2'd0) begin
      n_errors++;
      $display("FAIL reset: pause=%h flush=%b new_pc=%h to=%b sc=%0d fc=%0d st=%0d, required all zero",
               pause, flush, new_pc, stall_timeout, stall_cycles, flush_count, o_dbg_state);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 20; i++) begin
      apply(5'b0);
      @(negedge clk);
      got_exp = exp_q.pop_front();
      n_checks++;
      if (pause !== got_exp || flush !== 1'b0 || stall_timeout !== 1'b0) begin
        n_errors++;
        $display("FAIL idle[%0d]: pause=%h flush=%b to=%b, required %h 0 0", i, pause, flush, stall_timeout, got_exp);
      end
      advance(5'b0);
    end
  endtask

  task automatic test_ex_id();
    logic [4:0] seq [4] = '{5'b00110, 5'b00110, 5'b00110, 5'b00000};
    logic [5:0] req_p [4] = '{6'h0F, 6'h0F, 6'h0F, 6'h00};
    for (int i = 0; i < 4; i++) begin
      apply(seq[i]);
      @(negedge clk);
      got_exp = exp_q.pop_front();
      n_checks++;
      if (pause !== got_exp || pause !== req_p[i]) begin
        n_errors++;
        $display("FAIL ex_id[%0d]: pause=%h, required %h", i, pause, req_p[i]);
      end
      advance(seq[i]);
    end
  endtask

  // Exception sequence: exc pulse alone, or with a mem stall held through it.
  task automatic test_exception(input logic with_mem);
    logic [4:0] seq [5];
    logic [5:0] req_p [5] = '{6'h3F, 6'h3F, 6'h00, 6'h00, 6'h00};
    logic       req_f [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) seq[i] = {(i == 0), with_mem && (i < 3), 3'b000};
    if (with_mem) req_p[3] = 6'h00;
    for (int i = 0; i < 5; i++) begin
      apply(seq[i]);
      @(negedge clk);
      got_exp = exp_q.pop_front();
      n_checks++;
      if (pause !== got_exp || pause !== req_p[i] || flush !== req_f[i] ||
          flush !== exp_flush || new_pc !== exp_new_pc || o_dbg_state !== exp_state ||
          (req_f[i] && new_pc !== VEC)) begin
        n_errors++;
        $display("FAIL exception(mem=%b)[%0d]: pause=%h flush=%b new_pc=%h st=%0d, required %h %b %h %0d",
                 with_mem, i, pause, flush, new_pc, o_dbg_state, req_p[i], req_f[i], exp_new_pc, exp_state);
      end
      advance(seq[i]);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 11; i++) begin
      logic [4:0] r;
      r = (i < 8) ? 5'b01000 : 5'b00000;
      apply(r);
      @(negedge clk);
      got_exp = exp_q.pop_front();
      n_checks++;
      if (pause !== got_exp || stall_timeout !== exp_timeout) begin
        n_errors++;
        $display("FAIL timeout[%0d]: pause=%h to=%b, required %h %b", i, pause, stall_timeout, got_exp, exp_timeout);
      end
      advance(r);
    end
    @(negedge clk);
    n_checks++;
    if (stall_timeout !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_sticky: to=%b, required 1", stall_timeout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_perf();
    logic [4:0] seq [12];
    logic [31:0] want_sc, want_fc;
    do_reset();
    for (int i = 0; i < 12; i++) seq[i] = 5'b0;
    for (int i = 0; i < 5; i++) seq[i] = 5'b00001 << (i % 4);
    seq[5] = 5'b10000; seq[8] = 5'b10000;
    for (int i = 0; i < 12; i++) begin
      apply(seq[i]);
      @(negedge clk);
      got_exp = exp_q.pop_front();
      n_checks++;
      if (pause !== got_exp || stall_cycles !== exp_sc || flush_count !== exp_fc) begin
        n_errors++;
        $display("FAIL perf[%0d]: pause=%h sc=%0d fc=%0d, required %h %0d %0d",
                 i, pause, stall_cycles, flush_count, got_exp, exp_sc, exp_fc);
      end
      advance(seq[i]);
    end
`ifdef PIPE_CTRL_PERF_EN
    want_sc = 32'd9; want_fc = 32'd2;
`else
    want_sc = 32'd0; want_fc = 32'd0;
`endif
    @(negedge clk);
    n_checks++;
    if (stall_cycles !== want_sc || flush_count !== want_fc) begin
      n_errors++;
      $display("FAIL perf_totals: sc=%0d fc=%0d, required %0d %0d", stall_cycles, flush_count, want_sc, want_fc);
    end
    @(posedge clk); #1;
    // Start another exception and reset while in FLUSH: no redirect may remain.
    apply(5'b10000); advance(5'b10000);
    apply(5'b00000); advance(5'b00000);
    @(negedge clk);
    n_checks++;
    if (flush !== 1'b1 || o_dbg_state !== 2'd2) begin
      n_errors++;
      $display("FAIL perf_in_flush: flush=%b st=%0d, required 1 2", flush, o_dbg_state);
    end
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    n_checks++;
    if (flush !== 1'b0 || new_pc !== 32'h0 || o_dbg_state !== 2'd0 || pause !== 6'h00 ||
        stall_cycles !== 32'h0 || flush_count !== 32'h0 || stall_timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_in_flush: flush=%b new_pc=%h st=%0d pause=%h sc=%0d fc=%0d to=%b, required all zero",
               flush, new_pc, o_dbg_state, pause, stall_cycles, flush_count, stall_timeout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic [4:0] r;
      r[3:0] = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      r[4]   = ($urandom_range(0, 9) == 0);
      apply(r);
      @(negedge clk);
      got_exp = exp_q.pop_front();
      n_checks++;
      if (pause !== got_exp || flush !== exp_flush || new_pc !== exp_new_pc ||
          stall_timeout !== exp_timeout || stall_cycles !== exp_sc || flush_count !== exp_fc) begin
        n_errors++;
        $display("FAIL random[%0d] req=%b: pause=%h flush=%b pc=%h to=%b sc=%0d fc=%0d, required %h %b %h %b %0d %0d",
                 i, r, pause, flush, new_pc, stall_timeout, stall_cycles, flush_count,
                 got_exp, exp_flush, exp_new_pc, exp_timeout, exp_sc, exp_fc);
      end
      advance(r);
    end
  endtask

  initial begin
    rst = 1'b1;
    {exc_req, mem_stall_req, ex_stall_req, id_stall_req, if_stall_req} = 5'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_idle();
    test_ex_id();
    test_exception(1'b0);
    test_exception(1'b1);
    test_timeout();
    test_perf();
    do_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
